seq_detect_param: RTL and testbench

Parametrised serial sequence detector: samples one bit per qualified clock, compares the last PAT_W received bits against a runtime-programmable pattern, and emits a one-cycle match pulse. It is the general successor to the fixed "101" detector and sits between a serial bit source and downstream control logic. It adds:
- arbitrary pattern width and value;
- overlapping and non-overlapping detection modes;
- input qualification;
- an optional saturating match counter.

---
 rtl/seq_detect_param.sv | 78 +++++++
 tb/tb_seq_detect_param.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with runtime-loadable pattern
//   Parameters: PAT_W pattern length (2..16), PAT_INIT pattern after reset, CNT_W match counter width
//   clk_i        rising-edge clock for all state
//   rst_ni       asynchronous active-low reset (release expected synchronous to clk_i)
//   x_i          serial data bit, sampled only when x_vld_i is high
//   x_vld_i      qualifies x_i
//   ovl_i        1 = overlapping detection, 0 = non-overlapping
//   pat_ld_i     loads pat_in_i and discards history (wins over x_vld_i)
//   pat_in_i     new pattern value
//   z_o          one-cycle match pulse, the cycle after the completing bit
//   pat_o        current pattern register
//   match_cnt_o  saturating match count when SEQDET_COUNT_EN is defined, else constant 0
module seq_detect_param #(
    parameter int unsigned      PAT_W    = 3,
    parameter logic [PAT_W-1:0] PAT_INIT = 3'b101,
    parameter int unsigned      CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             x_i,
    input  logic             x_vld_i,
    input  logic             ovl_i,
    input  logic             pat_ld_i,
    input  logic [PAT_W-1:0] pat_in_i,
    output logic             z_o,
    output logic [PAT_W-1:0] pat_o,
    output logic [CNT_W-1:0] match_cnt_o
);
    localparam int unsigned     FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FULL = FW'(PAT_W);
    logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, new_hist;
    logic [FW-1:0]    fill_q, fill_d, new_fill;
    logic             z_q, z_d, hit;

    always_comb begin
        new_hist = {hist_q[PAT_W-2:0], x_i};
        new_fill = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        // fill guards against a match on stale or cleared history that merely equals pat
        hit      = x_vld_i && !pat_ld_i && (new_fill == FULL) && (new_hist == pat_q);
        hist_d   = pat_ld_i ? '0 : !x_vld_i ? hist_q : (hit && !ovl_i) ? '0 : new_hist;
        fill_d   = pat_ld_i ? '0 : !x_vld_i ? fill_q : (hit && !ovl_i) ? '0 : new_fill;
        z_d      = hit;
        pat_d    = pat_ld_i ? pat_in_i : pat_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            pat_q  <= PAT_INIT;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            pat_q  <= pat_d;
        end
    end

    assign z_o   = z_q;
    assign pat_o = pat_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // a load clears the count even when a pulse is being counted in the same cycle
    assign cnt_d = pat_ld_i ? '0 : (z_q && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign match_cnt_o = cnt_q;
`else
    assign match_cnt_o = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: table-driven bench for seq_detect_param (3-bit, 4-bit and 2-bit-counter instances)
module tb_seq_detect_param;
`ifdef SEQDET_COUNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif
    typedef struct {
        logic       x, vld, ovl, ld;
        logic [3:0] pin;
        logic       c3, z3, c4, z4;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       x = 1'b0, vld = 1'b0, ovl = 1'b0, ld = 1'b0;
    logic [3:0] pin = '0;
    logic       z3, z4, zs;
    logic [2:0] pat3, pats;
    logic [3:0] pat4;
    logic [7:0] cnt3, cnt4;
    logic [1:0] cnts;
    int         n_cmp = 0, n_bad = 0;
    vec_t       tbl[$];

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(3), .PAT_INIT(3'b101), .CNT_W(8)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .x_i(x), .x_vld_i(vld), .ovl_i(ovl), .pat_ld_i(ld),
        .pat_in_i(pin[2:0]), .z_o(z3), .pat_o(pat3), .match_cnt_o(cnt3));
    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(8)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .x_i(x), .x_vld_i(vld), .ovl_i(ovl), .pat_ld_i(ld),
        .pat_in_i(pin), .z_o(z4), .pat_o(pat4), .match_cnt_o(cnt4));
    seq_detect_param #(.PAT_W(3), .PAT_INIT(3'b111), .CNT_W(2)) us (
        .clk_i(clk), .rst_ni(rst_n), .x_i(x), .x_vld_i(vld), .ovl_i(ovl), .pat_ld_i(ld),
        .pat_in_i(pin[2:0]), .z_o(zs), .pat_o(pats), .match_cnt_o(cnts));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic xi, vi, oi, li, input logic [3:0] pi);
        x = xi; vld = vi; ovl = oi; ld = li; pin = pi;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic xi, vi, oi, li, input logic [3:0] pi,
                       input logic c3, e3, c4, e4);
        tbl.push_back('{x: xi, vld: vi, ovl: oi, ld: li, pin: pi, c3: c3, z3: e3, c4: c4, z4: e4});
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(tbl[i].x, tbl[i].vld, tbl[i].ovl, tbl[i].ld, tbl[i].pin);
            if (tbl[i].c3) chk($sformatf("z3[%0d]", i), 16'(z3), 16'(tbl[i].z3));
            if (tbl[i].c4) chk($sformatf("z4[%0d]", i), 16'(z4), 16'(tbl[i].z4));
        end
    endtask

    initial begin
        // overlapping 1,0,1,0,1 on pattern 101 (rows 0-5)
        add(1,1,1,0,4'h0, 1,0,0,0); add(0,1,1,0,4'h0, 1,0,0,0); add(1,1,1,0,4'h0, 1,1,0,0);
        add(0,1,1,0,4'h0, 1,0,0,0); add(1,1,1,0,4'h0, 1,1,0,0); add(0,0,1,0,4'h0, 1,0,0,0);
        // reload, non-overlapping same stream (rows 6-11)
        add(0,1,0,1,4'h5, 1,0,0,0); add(1,1,0,0,4'h0, 1,0,0,0); add(0,1,0,0,4'h0, 1,0,0,0);
        add(1,1,0,0,4'h0, 1,1,0,0); add(0,1,0,0,4'h0, 1,0,0,0); add(1,1,0,0,4'h0, 1,0,0,0);
        // qualification gaps (rows 12-18)
        add(0,1,0,1,4'h5, 1,0,0,0); add(1,1,0,0,4'h0, 1,0,0,0); add(0,0,0,0,4'h0, 1,0,0,0);
        add(0,0,0,0,4'h0, 1,0,0,0); add(0,0,0,0,4'h0, 1,0,0,0); add(0,1,0,0,4'h0, 1,0,0,0);
        add(1,1,0,0,4'h0, 1,1,0,0);
        // pattern 000: fill guard then back-to-back overlapping hits (rows 19-24)
        add(0,1,1,1,4'h0, 1,0,0,0); add(0,1,1,0,4'h0, 1,0,0,0); add(0,1,1,0,4'h0, 1,0,0,0);
        add(0,1,1,0,4'h0, 1,1,0,0); add(0,1,1,0,4'h0, 1,1,0,0); add(1,1,1,0,4'h0, 1,0,0,0);
        // 4-bit instance: load 1101 with x=1 presented (rows 25-30)
        add(1,1,0,1,4'hD, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,0);
        add(0,1,0,0,4'h0, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,1); add(0,0,0,0,4'h0, 0,0,1,0);
        // second hit, then load coinciding with the pulse (rows 31-39)
        add(1,1,0,0,4'h0, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,0); add(0,1,0,0,4'h0, 0,0,1,0);
        add(1,1,0,0,4'h0, 0,0,1,1); add(1,1,0,1,4'hD, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,0);
        add(0,1,0,0,4'h0, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,0); add(1,1,0,0,4'h0, 0,0,1,0);

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_z", 16'(z3), 16'(0));
            chk("rst_pat", 16'(pat3), 16'(3'b101));
            chk("rst_cnt", 16'(cnt3), 16'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
            chk("idle_z", 16'(z3), 16'(0));
        end

        run(0, 5);
        chk("ovl_cnt", 16'(cnt3), CE ? 16'(2) : 16'(0));
        run(6, 6);
        chk("ld_cnt3", 16'(cnt3), 16'(0));
        run(7, 19);
        chk("pat3_000", 16'(pat3), 16'(3'b000));
        run(20, 30);
        chk("cnt4_one", 16'(cnt4), CE ? 16'(1) : 16'(0));
        run(31, 35);
        chk("cnt4_clr", 16'(cnt4), 16'(0));
        chk("pat4", 16'(pat4), 16'(4'b1101));
        run(36, 39);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("pat3_rst", 16'(pat3), 16'(3'b101));
        chk("pats_rst", 16'(pats), 16'(3'b111));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
            chk($sformatf("zs[%0d]", i), 16'(zs), 16'(i >= 2));
            if (i == 7 || i == 9) chk("sat_cnt", 16'(cnts), CE ? 16'(3) : 16'(0));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_z", 16'(zs), 16'(0));
        chk("async_cnt", 16'(cnts), 16'(0));
        chk("async_pat", 16'(pats), 16'(3'b111));
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
            chk($sformatf("post_rst_zs[%0d]", i), 16'(zs), 16'(i == 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
